// File: rtl/turn_light_decoder.sv
// Tail-light frame decoder/checker: recovers stick direction and sweep step from the six
// lamp lines, validates the sweep sequence, counts sweeps and flags lamp faults.
module turn_light_decoder #(
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               L_outer,
  input  logic               L_middle,
  input  logic               L_inner,
  input  logic               R_inner,
  input  logic               R_middle,
  input  logic               R_outer,
  input  logic               clr_err,
  output logic [1:0]         dir,
  output logic [1:0]         step,
  output logic               sweep_done,
  output logic               pattern_err,
  output logic               seq_err,
  output logic               stuck_err,
  output logic               err_flag,
  output logic [COUNT_W-1:0] sweep_count
);

  typedef enum logic [2:0] {
    StOff, StR1, StR2, StR3, StL1, StL2, StL3, StResync
  } state_e;

  localparam logic [7:0] HoldLim = 8'(HOLD_MAX - 1);

  logic [5:0]         frame;
  logic [5:0]         prev_frame_q;
  state_e             state_q, state_d, frame_st;
  logic               legal, allowed;
  logic [1:0]         frame_dir, frame_step;
  logic [1:0]         dir_q, dir_d, step_q, step_d;
  logic               sweep_done_q, sweep_done_d;
  logic               pattern_err_q, pattern_err_d;
  logic               seq_err_q, seq_err_d;
  logic               stuck_err_q, stuck_err_d;
  logic               err_flag_q, err_flag_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [7:0]         hold_q, hold_d;

  assign frame = {L_outer, L_middle, L_inner, R_inner, R_middle, R_outer};

  always_comb begin
    legal      = 1'b1;
    frame_st   = StOff;
    frame_dir  = 2'b00;
    frame_step = 2'd0;
    case (frame)
      6'b000000: frame_st = StOff;
      6'b000100: begin frame_st = StR1; frame_dir = 2'b01; frame_step = 2'd1; end
      6'b000110: begin frame_st = StR2; frame_dir = 2'b01; frame_step = 2'd2; end
      6'b000111: begin frame_st = StR3; frame_dir = 2'b01; frame_step = 2'd3; end
      6'b001000: begin frame_st = StL1; frame_dir = 2'b10; frame_step = 2'd1; end
      6'b011000: begin frame_st = StL2; frame_dir = 2'b10; frame_step = 2'd2; end
      6'b111000: begin frame_st = StL3; frame_dir = 2'b10; frame_step = 2'd3; end
      default: begin
        legal    = 1'b0;
        frame_st = StResync;
      end
    endcase
  end

  // Hold, OFF, a restart on either side, or the next step on the same side.
  assign allowed = (frame_st == state_q) || (frame_st == StOff) ||
                   (frame_st == StR1) || (frame_st == StL1) ||
                   (state_q == StR1 && frame_st == StR2) ||
                   (state_q == StR2 && frame_st == StR3) ||
                   (state_q == StL1 && frame_st == StL2) ||
                   (state_q == StL2 && frame_st == StL3);

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    step_d        = step_q;
    pattern_err_d = 1'b0;
    seq_err_d     = 1'b0;
    sweep_done_d  = 1'b0;
    if (!legal) begin
      pattern_err_d = 1'b1;
      state_d       = StResync;
    end else begin
      seq_err_d    = (state_q != StResync) && !allowed;
      sweep_done_d = (state_q == StR2 && frame_st == StR3) ||
                     (state_q == StL2 && frame_st == StL3);
      state_d      = frame_st;
      dir_d        = frame_dir;
      step_d       = frame_step;
    end
  end

  // Stuck detection counts repeats of the raw frame, so an illegal frame breaks the run.
  always_comb begin
    hold_d      = 8'd0;
    stuck_err_d = 1'b0;
    if (legal && frame != 6'b000000 && frame == prev_frame_q) begin
      if (hold_q != HoldLim) begin
        hold_d      = hold_q + 8'd1;
        stuck_err_d = (hold_q + 8'd1 == HoldLim);
      end else begin
        hold_d = hold_q;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (sweep_done_d && count_q != '1) count_d = count_q + 1'b1;
    err_flag_d = pattern_err_d | seq_err_d | stuck_err_d | (err_flag_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StOff;
      prev_frame_q  <= 6'b000000;
      dir_q         <= 2'b00;
      step_q        <= 2'd0;
      sweep_done_q  <= 1'b0;
      pattern_err_q <= 1'b0;
      seq_err_q     <= 1'b0;
      stuck_err_q   <= 1'b0;
      err_flag_q    <= 1'b0;
      count_q       <= '0;
      hold_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      prev_frame_q  <= frame;
      dir_q         <= dir_d;
      step_q        <= step_d;
      sweep_done_q  <= sweep_done_d;
      pattern_err_q <= pattern_err_d;
      seq_err_q     <= seq_err_d;
      stuck_err_q   <= stuck_err_d;
      err_flag_q    <= err_flag_d;
      count_q       <= count_d;
      hold_q        <= hold_d;
    end
  end

  assign dir         = dir_q;
  assign step        = step_q;
  assign sweep_done  = sweep_done_q;
  assign pattern_err = pattern_err_q;
  assign seq_err     = seq_err_q;
  assign stuck_err   = stuck_err_q;
  assign err_flag    = err_flag_q;
  assign sweep_count = count_q;

endmodule
